// File: rtl/mdp3_tx_packetizer.sv
// mdp3_tx_packetizer: queues decoded order-book updates and serializes them
// into sequence-numbered MDP3-style packets on a 64-bit Avalon-ST source.
// Packet = header beat + n x (MSG_A, MSG_B, MSG_C), n in 1..MSGS_PER_PKT.
// Optional feature: define MDP3_TX_FLUSH_TIMEOUT_EN to flush partial packets
// after FLUSH_CYCLES idle cycles; without it partial messages wait.
module mdp3_tx_packetizer #(
  parameter int unsigned MSGS_PER_PKT = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [15:0] TEMPLATE_ID  = 16'd32,
  parameter int unsigned FLUSH_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        message_ready,
  input  logic [7:0]  NUM_ORDERS,
  input  logic [15:0] QUANTITY,
  input  logic [63:0] PRICE,
  input  logic [1:0]  ACTION,
  input  logic [1:0]  ENTRY_TYPE,
  input  logic [31:0] SECURITY_ID,
  output logic        encoder_ready,
  input  logic        ready,
  output logic        valid,
  output logic [63:0] data_out,
  output logic        start_packet,
  output logic        end_packet,
  output logic [2:0]  empty
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned REM_W  = 4;
  localparam int unsigned DATA_W = 64;
  localparam logic [15:0] MSG_SIZE = 16'd24;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_MSG_A = 3'd2;
  localparam logic [2:0] ST_MSG_B = 3'd3;
  localparam logic [2:0] ST_MSG_C = 3'd4;

  typedef struct packed {
    logic [31:0] security_id;
    logic [63:0] price;
    logic [15:0] quantity;
    logic [7:0]  num_orders;
    logic [1:0]  action;
    logic [1:0]  entry_type;
  } msg_t;

  // Elaboration-time guard on the parameter set
  if (MSGS_PER_PKT < 1 || MSGS_PER_PKT > 15 || FIFO_DEPTH < MSGS_PER_PKT ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FLUSH_CYCLES < 1) begin : g_bad_cfg
    $error("mdp3_tx_packetizer: illegal parameter set");
  end

  msg_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_c, pop_c, full_c;
  msg_t             in_msg_c, head_c, next_c;

  logic [2:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sop_q, sop_d;
  logic              eop_q, eop_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [31:0]       seq_q, seq_d;
  logic [31:0]       ts_q;
  logic              accept_c, start_c, flush_c;
  logic [REM_W-1:0]  n_c;

  assign in_msg_c = '{security_id: SECURITY_ID, price: PRICE, quantity: QUANTITY,
                      num_orders: NUM_ORDERS, action: ACTION, entry_type: ENTRY_TYPE};

  // A pop in the same cycle never frees a slot for that cycle's push
  assign full_c        = (count_q == CNT_W'(FIFO_DEPTH));
  assign encoder_ready = !full_c;
  assign push_c        = message_ready && !full_c;
  assign head_c        = mem_q[rd_ptr_q];
  assign next_c        = mem_q[rd_ptr_q + PTR_W'(1)];

  // FIFO storage, no reset needed on the data array
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_msg_c;
    end
  end

  // FIFO pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Free-running cycle counter used as the header timestamp
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

`ifdef MDP3_TX_FLUSH_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(FLUSH_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              partial_c;

  assign partial_c = (count_q != '0) && (count_q < CNT_W'(MSGS_PER_PKT));
  assign flush_c   = (state_q == ST_IDLE) && partial_c &&
                     (idle_cnt_q == IDLE_W'(FLUSH_CYCLES));

  // Idle timer runs only while a partial packet sits untouched in IDLE
  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == ST_IDLE) && partial_c && !push_c && !flush_c) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  // Idle timer register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign flush_c = 1'b0;
`endif

  assign accept_c = valid_q && ready;
  assign start_c  = (count_q >= CNT_W'(MSGS_PER_PKT)) || flush_c;
  assign n_c      = (count_q >= CNT_W'(MSGS_PER_PKT)) ? REM_W'(MSGS_PER_PKT)
                                                      : REM_W'(count_q);

  // Packet FSM: next state plus the next registered beat
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    rem_d   = rem_q;
    seq_d   = seq_q;
    pop_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_HDR;
          valid_d = 1'b1;
          sop_d   = 1'b1;
          eop_d   = 1'b0;
          data_d  = {seq_q, ts_q};
          rem_d   = n_c;
        end
      end
      ST_HDR: begin
        if (accept_c) begin
          state_d = ST_MSG_A;
          sop_d   = 1'b0;
          data_d  = {MSG_SIZE, TEMPLATE_ID, head_c.security_id};
        end
      end
      ST_MSG_A: begin
        if (accept_c) begin
          state_d = ST_MSG_B;
          data_d  = head_c.price;
        end
      end
      ST_MSG_B: begin
        if (accept_c) begin
          state_d = ST_MSG_C;
          data_d  = {head_c.quantity, head_c.num_orders, head_c.action,
                     head_c.entry_type, 36'd0};
          eop_d   = (rem_q == REM_W'(1));
        end
      end
      ST_MSG_C: begin
        if (accept_c) begin
          pop_c = 1'b1;
          rem_d = rem_q - REM_W'(1);
          eop_d = 1'b0;
          if (eop_q) begin
            seq_d = seq_q + 32'd1;
          end
          if (rem_q > REM_W'(1)) begin
            // The head pops on this edge, so the next message is one slot on
            state_d = ST_MSG_A;
            data_d  = {MSG_SIZE, TEMPLATE_ID, next_c.security_id};
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        data_d  = '0;
      end
    endcase
  end

  // FSM state, output beat and sequence number registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      rem_q   <= '0;
      seq_q   <= 32'd1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      rem_q   <= rem_d;
      seq_q   <= seq_d;
    end
  end

  assign valid        = valid_q;
  assign data_out     = data_q;
  assign start_packet = sop_q;
  assign end_packet   = eop_q;
  assign empty        = 3'd0;

endmodule

// File: tb/tb_mdp3_tx_packetizer.sv
// Bench for mdp3_tx_packetizer: a beat-queue model of the packet format
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_mdp3_tx_packetizer;

  localparam int MPP   = 4;
  localparam int DEPTH = 8;
  localparam int FLUSH = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        message_ready;
  logic [7:0]  NUM_ORDERS;
  logic [15:0] QUANTITY;
  logic [63:0] PRICE;
  logic [1:0]  ACTION;
  logic [1:0]  ENTRY_TYPE;
  logic [31:0] SECURITY_ID;
  logic        encoder_ready;
  logic        ready;
  logic        valid;
  logic [63:0] data_out;
  logic        start_packet;
  logic        end_packet;
  logic [2:0]  empty;

  mdp3_tx_packetizer #(
    .MSGS_PER_PKT(MPP), .FIFO_DEPTH(DEPTH), .TEMPLATE_ID(16'd32), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .message_ready(message_ready),
    .NUM_ORDERS(NUM_ORDERS), .QUANTITY(QUANTITY), .PRICE(PRICE),
    .ACTION(ACTION), .ENTRY_TYPE(ENTRY_TYPE), .SECURITY_ID(SECURITY_ID),
    .encoder_ready(encoder_ready), .ready(ready), .valid(valid),
    .data_out(data_out), .start_packet(start_packet), .end_packet(end_packet),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] sec;
    logic [63:0] price;
    logic [15:0] qty;
    logic [7:0]  num;
    logic [1:0]  act;
    logic [1:0]  et;
  } msg_t;

  typedef struct {
    logic [63:0] data;
    bit          sop;
    bit          eop;
    bit          is_c;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model state
  beat_t       pkt_q[$];
  msg_t        msgq[$];
  int          m_cnt;
  logic [31:0] m_seq;
  logic [31:0] m_ts;
  bit          m_valid, acc, psh, start, flush;
  int          n_take;
  msg_t        m;
  beat_t       b;
`ifdef MDP3_TX_FLUSH_TIMEOUT_EN
  int          m_idle;
`endif

  // Log of DUT beats actually transferred
  logic [63:0] log_d[$];
  bit          log_sop[$];
  bit          log_eop[$];
  int          log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic msg_t mk(input int k);
    msg_t r;
    r.sec   = 32'h10 + 32'(k);
    r.price = {32'hA5A5_0000 + 32'(k), 32'h0000_1000 * 32'(k)};
    r.qty   = 16'h0100 + 16'(k);
    r.num   = 8'(k);
    r.act   = 2'(k);
    r.et    = 2'(k + 1);
    return r;
  endfunction

  function automatic beat_t mkbeat(input logic [63:0] d, input bit s, input bit e, input bit c);
    beat_t r;
    r.data = d; r.sop = s; r.eop = e; r.is_c = c;
    return r;
  endfunction

  // Model + compare, evaluated mid-cycle for the coming rising edge
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_sop", 64'(start_packet), 64'd0);
      chk("rst_eop", 64'(end_packet), 64'd0);
      chk("rst_data", data_out, 64'd0);
      chk("rst_empty", 64'(empty), 64'd0);
      chk("rst_enc_rdy", 64'(encoder_ready), 64'd1);
      pkt_q.delete();
      msgq.delete();
      m_cnt = 0;
      m_seq = 32'd1;
      m_ts  = 32'd0;
`ifdef MDP3_TX_FLUSH_TIMEOUT_EN
      m_idle = 0;
`endif
    end else begin
      m_valid = (pkt_q.size() > 0);
      chk("valid", 64'(valid), 64'(m_valid));
      if (m_valid) begin
        chk("data", data_out, pkt_q[0].data);
        chk("sop", 64'(start_packet), 64'(pkt_q[0].sop));
        chk("eop", 64'(end_packet), 64'(pkt_q[0].eop));
      end
      chk("empty", 64'(empty), 64'd0);
      chk("enc_rdy", 64'(encoder_ready), 64'(m_cnt < DEPTH));
      if (valid && ready) begin
        log_d.push_back(data_out);
        log_sop.push_back(start_packet);
        log_eop.push_back(end_packet);
        log_cyc.push_back(cyc);
      end
      acc = m_valid && ready;
      psh = message_ready && (m_cnt < DEPTH);
`ifdef MDP3_TX_FLUSH_TIMEOUT_EN
      flush = !m_valid && (msgq.size() > 0) && (msgq.size() < MPP) && (m_idle == FLUSH);
`else
      flush = 1'b0;
`endif
      start = !m_valid && ((msgq.size() >= MPP) || flush);
`ifdef MDP3_TX_FLUSH_TIMEOUT_EN
      if (!m_valid && !start && (msgq.size() > 0) && (msgq.size() < MPP) && !psh) m_idle++;
      else m_idle = 0;
`endif
      if (acc) begin
        b = pkt_q.pop_front();
        if (b.is_c) m_cnt--;
        if (b.eop) m_seq = m_seq + 32'd1;
      end
      if (start) begin
        n_take = (msgq.size() > MPP) ? MPP : msgq.size();
        pkt_q.push_back(mkbeat({m_seq, m_ts}, 1'b1, 1'b0, 1'b0));
        for (int i = 0; i < n_take; i++) begin
          m = msgq.pop_front();
          pkt_q.push_back(mkbeat({16'd24, 16'd32, m.sec}, 1'b0, 1'b0, 1'b0));
          pkt_q.push_back(mkbeat(m.price, 1'b0, 1'b0, 1'b0));
          pkt_q.push_back(mkbeat({m.qty, m.num, m.act, m.et, 36'd0}, 1'b0, (i == n_take - 1), 1'b1));
        end
      end
      if (psh) begin
        m.sec = SECURITY_ID; m.price = PRICE; m.qty = QUANTITY;
        m.num = NUM_ORDERS; m.act = ACTION; m.et = ENTRY_TYPE;
        msgq.push_back(m);
        m_cnt++;
      end
      m_ts = m_ts + 32'd1;
    end
  end

  task automatic drive_msg(input int k);
    msg_t r;
    r = mk(k);
    SECURITY_ID = r.sec; PRICE = r.price; QUANTITY = r.qty;
    NUM_ORDERS = r.num; ACTION = r.act; ENTRY_TYPE = r.et;
    message_ready = 1'b1;
    @(posedge clk); #1;
    message_ready = 1'b0;
  endtask

  task automatic do_reset();
    message_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic log_clear();
    log_d.delete(); log_sop.delete(); log_eop.delete(); log_cyc.delete();
  endtask

  task automatic wait_beats(input int target, input int budget);
    int w;
    w = 0;
    while (log_d.size() < target && w < budget) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [63:0] v;
  int          push_cyc;
  int          n_eop;

  initial begin
    reset_n = 1'b0; message_ready = 1'b0; ready = 1'b1;
    NUM_ORDERS = '0; QUANTITY = '0; PRICE = '0; ACTION = '0; ENTRY_TYPE = '0; SECURITY_ID = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // Full packet
    log_clear();
    for (int k = 1; k <= 4; k++) drive_msg(k);
    wait_beats(13, 100);
    chk("t1_len", 64'(log_d.size()), 64'd13);
    if (log_d.size() == 13) begin
      v = log_d[0];
      chk("t1_hdr_seq", 64'(v[63:32]), 64'd1);
      chk("t1_hdr_ts", 64'(v[31:0]), 64'd4);
      chk("t1_beat1", log_d[1], 64'h0018_0020_0000_0011);
      chk("t1_beat3", log_d[3], 64'h0101_0160_0000_0000);
      v = log_d[10];
      chk("t1_beat10_sec", 64'(v[31:0]), 64'h14);
      chk("t1_sop0", 64'(log_sop[0]), 64'd1);
      chk("t1_eop11", 64'(log_eop[11]), 64'd0);
      chk("t1_eop12", 64'(log_eop[12]), 64'd1);
      chk("t1_no_gap", 64'(log_cyc[12] - log_cyc[0]), 64'd12);
    end

    // Backpressure: ready pattern 1-0-0-1 across the whole packet
    log_clear();
    for (int k = 5; k <= 8; k++) drive_msg(k);
    for (int i = 0; i < 48; i++) begin
      ready = ((i % 4) == 0) || ((i % 4) == 3);
      @(posedge clk); #1;
    end
    ready = 1'b1;
    wait_beats(13, 100);
    chk("t2_len", 64'(log_d.size()), 64'd13);
    if (log_d.size() == 13) begin
      v = log_d[0];
      chk("t2_hdr_seq", 64'(v[63:32]), 64'd2);
      chk("t2_beat2_price", log_d[2], 64'hA5A5_0005_0000_5000);
      chk("t2_beat1", log_d[1], 64'h0018_0020_0000_0015);
    end

    // FIFO full with the sink stalled
    do_reset();
    log_clear();
    ready = 1'b0;
    for (int k = 9; k <= 16; k++) drive_msg(k);
    chk("t3_full", 64'(encoder_ready), 64'd0);
    drive_msg(17);
    ready = 1'b1;
    wait_beats(26, 200);
    chk("t3_len", 64'(log_d.size()), 64'd26);
    if (log_d.size() == 26) begin
      v = log_d[0];
      chk("t3_p1_seq", 64'(v[63:32]), 64'd1);
      v = log_d[13];
      chk("t3_p2_seq", 64'(v[63:32]), 64'd2);
      v = log_d[14];
      chk("t3_p2_first_sec", 64'(v[31:0]), 64'h1D);
      v = log_d[23];
      chk("t3_p2_last_sec", 64'(v[31:0]), 64'h20);
      chk("t3_p2_eop", 64'(log_eop[25]), 64'd1);
    end
    chk("t3_enc_rdy_after", 64'(encoder_ready), 64'd1);

    // Reset during MSG_A
    do_reset();
    log_clear();
    for (int k = 21; k <= 24; k++) drive_msg(k);
    for (int w = 0; w < 50 && log_d.size() == 0; w++) begin
      @(posedge clk); #1;
    end
    chk("t4_hdr_seen", 64'(log_d.size()), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t4_valid_rst", 64'(valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    n_eop = 0;
    foreach (log_eop[i]) if (log_eop[i]) n_eop++;
    chk("t4_no_eop", 64'(n_eop), 64'd0);
    log_clear();
    for (int k = 25; k <= 28; k++) drive_msg(k);
    wait_beats(13, 100);
    chk("t4_len", 64'(log_d.size()), 64'd13);
    if (log_d.size() == 13) begin
      v = log_d[0];
      chk("t4_hdr_seq", 64'(v[63:32]), 64'd1);
      v = log_d[1];
      chk("t4_beat1_sec", 64'(v[31:0]), 64'h29);
    end

    // Single message, then idle
    do_reset();
    log_clear();
    drive_msg(30);
    push_cyc = cyc;
`ifdef MDP3_TX_FLUSH_TIMEOUT_EN
    wait_beats(4, 200);
    chk("t5_len", 64'(log_d.size()), 64'd4);
    if (log_d.size() == 4) begin
      chk("t5_hdr_delay", 64'(log_cyc[0] - push_cyc), 64'd65);
      chk("t5_sop", 64'(log_sop[0]), 64'd1);
      chk("t5_eop3", 64'(log_eop[3]), 64'd1);
    end
`else
    repeat (1000) @(posedge clk);
    #1;
    chk("t5_no_flush", 64'(log_d.size()), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
